// File: rtl/cnn_param_loader_if.sv
// rtl/cnn_param_loader_if.sv - parameter word input and byte-wide RAM write port bundle
interface cnn_param_loader_if #(
    parameter int ADDR_W = 16
);
    logic [15:0]       Din;
    logic              dinValid;
    logic              dinReady;
    logic              loadDone;
    logic [ADDR_W-1:0] ramAddress;
    logic [7:0]        ramDataIn;
    logic              writeSignal;

    modport master (
        output Din, dinValid, loadDone,
        input  dinReady, ramAddress, ramDataIn, writeSignal
    );

    modport slave (
        input  Din, dinValid, loadDone,
        output dinReady, ramAddress, ramDataIn, writeSignal
    );
endinterface

// File: rtl/cnn_param_loader.sv
// rtl/cnn_param_loader.sv - computes network offsets, writes the header, then streams 16-bit parameters into byte RAM
module cnn_param_loader #(
    parameter int ADDR_W     = 16,
    parameter int MAX_LAYERS = 10
) (
    input  logic                        clk,
    input  logic                        RST,
    input  logic                        start,
    input  logic [7:0]                  filterSize,
    input  logic [3:0]                  numLayers,
    input  logic [8*MAX_LAYERS-1:0]     filterCounts,
    input  logic [8*(MAX_LAYERS-1)-1:0] denseCounts,
    cnn_param_loader_if.slave           bus,
    output logic [15:0]                 filterOffset,
    output logic [15:0]                 denseOffset,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);
    typedef enum logic [2:0] {IDLE, CALC, HDR, STR_HI, STR_LO, FIN} state_t;

    // Highest pointer at which a whole word (two bytes) still fits below the top of RAM.
    localparam logic [ADDR_W:0] PTR_LIMIT = (ADDR_W+1)'((1 << ADDR_W) - 2);

    state_t                        state, stateNext;
    logic [7:0]                    cfgFs;
    logic [3:0]                    cfgL;
    logic [8*MAX_LAYERS-1:0]       cfgFc;
    logic [8*(MAX_LAYERS-1)-1:0]   cfgDc;
    logic [31:0]                   acc;
    logic [7:0]                    idx;
    logic [ADDR_W:0]               ptr;
    logic [7:0]                    loByte;
    logic                          endSeen;

    logic [7:0]        hdrLen, hdrLenIn, layerCnt, hdrByte, fcIdx, dcIdx;
    logic [15:0]       sq;
    logic [31:0]       accNext;
    logic              badL, accOvf, lastLayer, handshake, ptrFull;
    logic              wrEn, errSet;
    logic [ADDR_W-1:0] wrAddr;
    logic [7:0]        wrData;

    assign hdrLen    = {3'b000, cfgL, 1'b0} + 8'd5;
    assign hdrLenIn  = {3'b000, numLayers, 1'b0} + 8'd5;
    assign sq        = 16'(cfgFs) * 16'(cfgFs);
    assign layerCnt  = 8'(cfgFc >> {idx, 3'b000});
    assign accNext   = acc + 32'(layerCnt) * (32'(sq) + 32'd1);
    assign accOvf    = (accNext >> ADDR_W) != 32'd0;
    assign lastLayer = (idx + 8'd1) == {4'b0000, cfgL};
    assign badL      = (numLayers == 4'd0) || (int'(numLayers) > MAX_LAYERS);
    assign handshake = bus.dinValid && bus.dinReady;
    assign ptrFull   = ptr > PTR_LIMIT;
    assign fcIdx     = idx - 8'd6;
    assign dcIdx     = idx - 8'd6 - {4'b0000, cfgL};

    always_comb begin
        hdrByte = 8'h00;
        case (idx)
            8'd0: hdrByte = cfgFs;
            8'd1: hdrByte = {4'b0000, cfgL};
            8'd2: hdrByte = filterOffset[15:8];
            8'd3: hdrByte = filterOffset[7:0];
            8'd4: hdrByte = denseOffset[15:8];
            8'd5: hdrByte = denseOffset[7:0];
            default: begin
                if (idx < 8'd6 + {4'b0000, cfgL})
                    hdrByte = 8'(cfgFc >> {fcIdx, 3'b000});
                else
                    hdrByte = 8'(cfgDc >> {dcIdx, 3'b000});
            end
        endcase
    end

    always_comb begin
        stateNext = state;
        wrEn      = 1'b0;
        wrAddr    = ptr[ADDR_W-1:0];
        wrData    = 8'h00;
        errSet    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (badL) begin
                        stateNext = FIN;
                        errSet    = 1'b1;
                    end else begin
                        stateNext = CALC;
                    end
                end
            end
            CALC: begin
                if (lastLayer) begin
                    if (accOvf) begin
                        stateNext = FIN;
                        errSet    = 1'b1;
                    end else begin
                        stateNext = HDR;
                    end
                end
            end
            HDR: begin
                // One idle edge after the last header byte before the stream opens.
                if (idx == hdrLen) begin
                    stateNext = STR_HI;
                end else begin
                    wrEn   = 1'b1;
                    wrAddr = ADDR_W'(idx);
                    wrData = hdrByte;
                end
            end
            STR_HI: begin
                if (handshake) begin
                    if (ptrFull) begin
                        stateNext = FIN;
                        errSet    = 1'b1;
                    end else begin
                        stateNext = STR_LO;
                        wrEn      = 1'b1;
                        wrData    = bus.Din[15:8];
                    end
                end else if (bus.loadDone) begin
                    stateNext = FIN;
                end
            end
            STR_LO: begin
                wrEn      = 1'b1;
                wrAddr    = ptr[ADDR_W-1:0] + ADDR_W'(1);
                wrData    = loByte;
                stateNext = (endSeen || bus.loadDone) ? FIN : STR_HI;
            end
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state           <= IDLE;
            cfgFs           <= '0;
            cfgL            <= '0;
            cfgFc           <= '0;
            cfgDc           <= '0;
            acc             <= '0;
            idx             <= '0;
            ptr             <= '0;
            loByte          <= '0;
            endSeen         <= 1'b0;
            bus.ramAddress  <= '0;
            bus.ramDataIn   <= '0;
            bus.writeSignal <= 1'b0;
            bus.dinReady    <= 1'b0;
            filterOffset    <= '0;
            denseOffset     <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            state           <= stateNext;
            busy            <= (stateNext != IDLE);
            done            <= (state == FIN);
            bus.dinReady    <= (stateNext == STR_HI);
            bus.writeSignal <= wrEn;
            if (wrEn) begin
                bus.ramAddress <= wrAddr;
                bus.ramDataIn  <= wrData;
            end
            if (errSet)
                error <= 1'b1;
            else if (state == IDLE && start)
                error <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        cfgFs        <= filterSize;
                        cfgL         <= numLayers;
                        cfgFc        <= filterCounts;
                        cfgDc        <= denseCounts;
                        acc          <= 32'(hdrLenIn);
                        idx          <= '0;
                        endSeen      <= 1'b0;
                        filterOffset <= '0;
                        denseOffset  <= '0;
                    end
                end
                CALC: begin
                    acc <= accNext;
                    idx <= idx + 8'd1;
                    if (lastLayer) begin
                        idx          <= '0;
                        filterOffset <= {8'h00, hdrLen};
                        denseOffset  <= accNext[15:0];
                        ptr          <= (ADDR_W+1)'(hdrLen);
                    end
                end
                HDR: idx <= idx + 8'd1;
                STR_HI: begin
                    if (handshake && !ptrFull) begin
                        loByte  <= bus.Din[7:0];
                        endSeen <= bus.loadDone;
                    end
                end
                STR_LO: ptr <= ptr + (ADDR_W+1)'(2);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_param_loader.sv
// tb/tb_cnn_param_loader.sv - directed bench for cnn_param_loader (16-bit and 8-bit address instances)
module tb_cnn_param_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        RST, start16, start8;
    logic [7:0]  filterSize;
    logic [3:0]  numLayers;
    logic [79:0] filterCounts;
    logic [71:0] denseCounts;
    logic [15:0] din;
    logic        dinValid, loadDone;
    logic [15:0] fo16, do16, fo8, do8;
    logic        busy16, done16, err16, busy8, done8, err8;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int logA16[$], logD16[$], logC16[$];
    int logA8[$], logD8[$];

    cnn_param_loader_if #(.ADDR_W(16)) bus16 ();
    cnn_param_loader_if #(.ADDR_W(8))  bus8 ();

    assign bus16.Din      = din;
    assign bus16.dinValid = dinValid;
    assign bus16.loadDone = loadDone;
    assign bus8.Din       = din;
    assign bus8.dinValid  = dinValid;
    assign bus8.loadDone  = loadDone;

    cnn_param_loader #(.ADDR_W(16), .MAX_LAYERS(10)) dut (
        .clk(clk), .RST(RST), .start(start16), .filterSize(filterSize), .numLayers(numLayers),
        .filterCounts(filterCounts), .denseCounts(denseCounts), .bus(bus16),
        .filterOffset(fo16), .denseOffset(do16), .busy(busy16), .done(done16), .error(err16)
    );

    cnn_param_loader #(.ADDR_W(8), .MAX_LAYERS(10)) dut8 (
        .clk(clk), .RST(RST), .start(start8), .filterSize(filterSize), .numLayers(numLayers),
        .filterCounts(filterCounts), .denseCounts(denseCounts), .bus(bus8),
        .filterOffset(fo8), .denseOffset(do8), .busy(busy8), .done(done8), .error(err8)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus16.writeSignal === 1'b1) begin
            logA16.push_back(int'(bus16.ramAddress));
            logD16.push_back(int'(bus16.ramDataIn));
            logC16.push_back(cyc);
        end
        if (bus8.writeSignal === 1'b1) begin
            logA8.push_back(int'(bus8.ramAddress));
            logD8.push_back(int'(bus8.ramDataIn));
        end
    end

    task automatic test_reset();
        RST = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({bus16.ramAddress, bus16.ramDataIn, bus16.writeSignal, bus16.dinReady, busy16, done16, err16, fo16, do16} !== '0) begin
            miscompares++;
            $display("FAIL reset16 outputs got addr=%0h data=%0h wr=%b rdy=%b busy=%b done=%b err=%b fo=%0d do=%0d, want all 0",
                     bus16.ramAddress, bus16.ramDataIn, bus16.writeSignal, bus16.dinReady, busy16, done16, err16, fo16, do16);
        end
        vectors++;
        if ({bus8.ramAddress, bus8.ramDataIn, bus8.writeSignal, bus8.dinReady, busy8, done8, err8, fo8, do8} !== '0) begin
            miscompares++;
            $display("FAIL reset8 outputs not all zero (addr=%0h wr=%b busy=%b err=%b)", bus8.ramAddress, bus8.writeSignal, busy8, err8);
        end
        RST = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_header(input string tag);
        int e0, t;
        int expA[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        int expD[11] = '{5, 3, 0, 11, 8'h1B, 8'h77, 100, 90, 80, 90, 80};
        filterSize   = 8'd5;
        numLayers    = 4'd3;
        filterCounts = '0;
        filterCounts[23:0] = {8'd80, 8'd90, 8'd100};
        denseCounts  = '0;
        denseCounts[15:0] = {8'd80, 8'd90};
        logA16.delete(); logD16.delete(); logC16.delete();
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        e0 = cyc;
        vectors++;
        if (busy16 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start got %b want 1", tag, busy16);
        end
        t = 0;
        while (bus16.dinReady !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (cyc - e0 !== 15) begin
            miscompares++;
            $display("FAIL %s dinReady_rise got edge %0d want 15", tag, cyc - e0);
        end
        vectors++;
        if (fo16 !== 16'd11) begin
            miscompares++;
            $display("FAIL %s filterOffset got %0d want 11", tag, fo16);
        end
        vectors++;
        if (do16 !== 16'd7031) begin
            miscompares++;
            $display("FAIL %s denseOffset got %0d want 7031", tag, do16);
        end
        vectors++;
        if (logA16.size() !== 11) begin
            miscompares++;
            $display("FAIL %s header_write_count got %0d want 11", tag, logA16.size());
        end
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if (i >= logA16.size()) begin
                miscompares++;
                $display("FAIL %s header_byte%0d missing, want %0d:%0h", tag, i, expA[i], expD[i]);
            end else if (logA16[i] !== expA[i] || logD16[i] !== expD[i] || logC16[i] !== e0 + 4 + i) begin
                miscompares++;
                $display("FAIL %s header_byte%0d got %0d:%0h at edge %0d want %0d:%0h at edge %0d",
                         tag, i, logA16[i], logD16[i], logC16[i] - e0, expA[i], expD[i], 4 + i);
            end
        end
    endtask

    task automatic test_stream();
        logic [3:0] rs;
        int c0;
        int expA[4] = '{11, 12, 13, 14};
        int expD[4] = '{8'hA5, 8'hC3, 8'h12, 8'h34};
        logA16.delete(); logD16.delete(); logC16.delete();
        c0 = cyc;
        rs[3] = bus16.dinReady;
        din = 16'hA5C3;
        dinValid = 1'b1;
        @(negedge clk);
        rs[2] = bus16.dinReady;
        din = 16'h1234;
        @(negedge clk);
        rs[1] = bus16.dinReady;
        @(negedge clk);
        rs[0] = bus16.dinReady;
        dinValid = 1'b0;
        @(negedge clk);
        vectors++;
        if (rs !== 4'b1010) begin
            miscompares++;
            $display("FAIL stream_ready_pattern got %b want 1010", rs);
        end
        vectors++;
        if (logA16.size() !== 4) begin
            miscompares++;
            $display("FAIL stream_write_count got %0d want 4", logA16.size());
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= logA16.size() || logA16[i] !== expA[i] || logD16[i] !== expD[i] || logC16[i] !== c0 + 1 + i) begin
                miscompares++;
                $display("FAIL stream_byte%0d want %0d:%0h at cycle %0d", i, expA[i], expD[i], c0 + 1 + i);
            end
        end
    endtask

    task automatic test_stream_end();
        int doneCnt;
        logA16.delete(); logD16.delete(); logC16.delete();
        din = 16'hBEEF;
        dinValid = 1'b1;
        loadDone = 1'b1;
        @(negedge clk);
        dinValid = 1'b0;
        loadDone = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done16 === 1'b1) doneCnt++;
        end
        vectors++;
        if (logA16.size() !== 2 || logA16[0] !== 15 || logD16[0] !== 8'hBE || logA16[1] !== 16 || logD16[1] !== 8'hEF) begin
            miscompares++;
            $display("FAIL end_writes got %0d writes want 15:be 16:ef", logA16.size());
        end
        vectors++;
        if (doneCnt !== 1) begin
            miscompares++;
            $display("FAIL end_done_pulses got %0d want 1", doneCnt);
        end
        vectors++;
        if (busy16 !== 1'b0 || err16 !== 1'b0) begin
            miscompares++;
            $display("FAIL end_busy_error got busy=%b err=%b want 0 0", busy16, err16);
        end
    endtask

    task automatic test_bad_config();
        int e0;
        logA16.delete(); logD16.delete(); logC16.delete();
        numLayers = 4'd0;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        e0 = cyc;
        vectors++;
        if (err16 !== 1'b1 || busy16 !== 1'b1) begin
            miscompares++;
            $display("FAIL zeroL_error got err=%b busy=%b want 1 1", err16, busy16);
        end
        @(negedge clk);
        vectors++;
        if (done16 !== 1'b1) begin
            miscompares++;
            $display("FAIL zeroL_done got %b want 1", done16);
        end
        @(negedge clk);
        vectors++;
        if (done16 !== 1'b0 || busy16 !== 1'b0 || err16 !== 1'b1 || logA16.size() !== 0) begin
            miscompares++;
            $display("FAIL zeroL_after got done=%b busy=%b err=%b writes=%0d want 0 0 1 0", done16, busy16, err16, logA16.size());
        end

        filterSize   = 8'd255;
        numLayers    = 4'd10;
        filterCounts = {10{8'hFF}};
        denseCounts  = {9{8'hFF}};
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        e0 = cyc;
        vectors++;
        if (err16 !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_error_cleared got %b want 0", err16);
        end
        while (cyc < e0 + 9) @(negedge clk);
        vectors++;
        if (err16 !== 1'b0 || busy16 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_calc_edge9 got err=%b busy=%b want 0 1", err16, busy16);
        end
        @(negedge clk);
        vectors++;
        if (err16 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_error_edge10 got %b want 1", err16);
        end
        @(negedge clk);
        vectors++;
        if (done16 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_done_edge11 got %b want 1", done16);
        end
        @(negedge clk);
        vectors++;
        if (busy16 !== 1'b0 || err16 !== 1'b1 || logA16.size() !== 0) begin
            miscompares++;
            $display("FAIL ovf_after got busy=%b err=%b writes=%0d want 0 1 0", busy16, err16, logA16.size());
        end
    endtask

    task automatic test_wrap();
        int t, bad;
        int hdrD[7] = '{1, 1, 0, 7, 0, 7, 0};
        filterSize   = 8'd1;
        numLayers    = 4'd1;
        filterCounts = '0;
        denseCounts  = '0;
        logA8.delete(); logD8.delete();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int k = 0; k < 125; k++) begin
            t = 0;
            while (bus8.dinReady !== 1'b1 && t < 40) begin
                @(negedge clk);
                t++;
            end
            din = {8'(k), 8'(k + 100)};
            dinValid = 1'b1;
            @(negedge clk);
        end
        dinValid = 1'b0;
        vectors++;
        if (err8 !== 1'b1 || bus8.writeSignal !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_error got err=%b wr=%b want 1 0", err8, bus8.writeSignal);
        end
        vectors++;
        if (fo8 !== 16'd7 || do8 !== 16'd7) begin
            miscompares++;
            $display("FAIL wrap_offsets got fo=%0d do=%0d want 7 7", fo8, do8);
        end
        @(negedge clk);
        vectors++;
        if (done8 !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_done got %b want 1", done8);
        end
        vectors++;
        if (logA8.size() !== 255) begin
            miscompares++;
            $display("FAIL wrap_write_count got %0d want 255", logA8.size());
        end
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            if (i >= logA8.size()) bad++;
            else if (i < 7) begin
                if (logA8[i] !== i || logD8[i] !== hdrD[i]) bad++;
            end else if (logA8[i] !== i) bad++;
            else if (((i - 7) % 2) == 0 && logD8[i] !== (i - 7) / 2) bad++;
            else if (((i - 7) % 2) == 1 && logD8[i] !== (((i - 8) / 2 + 100) & 255)) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL wrap_contents got %0d bad bytes want 0", bad);
        end
        vectors++;
        if (logA8.size() < 255 || logA8[253] !== 253 || logD8[253] !== 123 || logA8[254] !== 254 || logD8[254] !== 223) begin
            miscompares++;
            $display("FAIL wrap_last_word want 253:7b 254:df");
        end
    endtask

    task automatic test_reset_restart();
        test_header("pre_reset");
        logA16.delete(); logD16.delete(); logC16.delete();
        din = 16'hCAFE;
        dinValid = 1'b1;
        @(negedge clk);
        RST = 1'b1;
        dinValid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus16.ramAddress, bus16.ramDataIn, bus16.writeSignal, bus16.dinReady, busy16, done16, err16, fo16, do16} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs got addr=%0h data=%0h wr=%b rdy=%b busy=%b fo=%0d do=%0d want all 0",
                     bus16.ramAddress, bus16.ramDataIn, bus16.writeSignal, bus16.dinReady, busy16, fo16, do16);
        end
        vectors++;
        if (logA16.size() !== 1 || logA16[0] !== 11 || logD16[0] !== 8'hCA) begin
            miscompares++;
            $display("FAIL midreset_writes got %0d writes want only 11:ca", logA16.size());
        end
        RST = 1'b0;
        @(negedge clk);
        test_header("restart");
    endtask

    initial begin
        RST = 1'b1;
        start16 = 1'b0;
        start8 = 1'b0;
        filterSize = '0;
        numLayers = '0;
        filterCounts = '0;
        denseCounts = '0;
        din = '0;
        dinValid = 1'b0;
        loadDone = 1'b0;
        @(negedge clk);
        test_reset();
        test_header("header");
        test_stream();
        test_stream_end();
        test_bad_config();
        test_wrap();
        test_reset_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
